apb_ahb_bridge_n: RTL and testbench

Parametrised APB-to-AHB-Lite bridge with an N-slave address decoder. It converts one APB access into one single-beat AHB transfer to the selected slave and returns read data and status on APB. Unlike the fixed-map predecessor it adds:

- parameter-driven base/mask regions;
- byte/halfword sizing from `pstrb`;
- `pslverr` reporting for decode miss, illegal strobes, `HRESP` ERROR and slave timeout.

It sits between the APB peripheral fabric and the AHB memory/peripheral slaves.

---
 rtl/apb_ahb_pkg.sv | 48 ++++
 rtl/apb_ahb_bridge_n_if.sv | 40 ++++
 rtl/apb_ahb_decode.sv | 27 ++
 rtl/apb_ahb_bridge_n.sv | 132 +++++++++++++
 tb/tb_apb_ahb_bridge_n.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_ahb_pkg.sv
// apb_ahb_pkg: shared codes for the APB-to-AHB-Lite bridge.
// State encoding, HTRANS/HRESP/HSIZE codes and the write-strobe sizing helper.
package apb_ahb_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef struct packed {
    logic       ok;
    logic [2:0] size;
    logic [1:0] lo;
  } strb_t;

  // Reads are always word-sized; writes map the strobe pattern to
  // a transfer size and the low address bits of the active lane(s).
  function automatic strb_t strb_chk(input logic wr, input logic [3:0] s);
    strb_t r;
    r.ok   = 1'b1;
    r.size = HSIZE_WORD;
    r.lo   = 2'd0;
    if (wr) begin
      case (s)
        4'b1111: r.size = HSIZE_WORD;
        4'b0011: r.size = HSIZE_HALF;
        4'b1100: begin r.size = HSIZE_HALF; r.lo = 2'd2; end
        4'b0001: begin r.size = HSIZE_BYTE; r.lo = 2'd0; end
        4'b0010: begin r.size = HSIZE_BYTE; r.lo = 2'd1; end
        4'b0100: begin r.size = HSIZE_BYTE; r.lo = 2'd2; end
        4'b1000: begin r.size = HSIZE_BYTE; r.lo = 2'd3; end
        default: r.ok = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_ahb_bridge_n_if.sv
// apb_ahb_bridge_n_if: APB slave side plus AHB-Lite master side of the bridge.
// master = APB master / AHB slaves view, slave = bridge view.
interface apb_ahb_bridge_n_if #(
  parameter int NSLV = 4,
  parameter int AW   = 32
);
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [AW-1:0]      paddr;
  logic [31:0]        pwdata;
  logic [3:0]         pstrb;
  logic [31:0]        prdata;
  logic               pready;
  logic               pslverr;
  logic [AW-1:0]      HADDR;
  logic               HWRITE;
  logic [2:0]         HSIZE;
  logic [2:0]         HBURST;
  logic [1:0]         HTRANS;
  logic [31:0]        HWDATA;
  logic [NSLV-1:0]    HSEL;
  logic [NSLV*32-1:0] HRDATA;
  logic [NSLV-1:0]    HREADY;
  logic [NSLV*2-1:0]  HRESP;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    output HRDATA, HREADY, HRESP,
    input  prdata, pready, pslverr,
    input  HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HSEL
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    input  HRDATA, HREADY, HRESP,
    output prdata, pready, pslverr,
    output HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HSEL
  );
endinterface

// File: rtl/apb_ahb_decode.sv
// apb_ahb_decode: combinational priority decoder over packed BASE/MASK regions.
// Ports: addr in; hit one-hot (lowest matching index), miss when no region matches.
module apb_ahb_decode #(
  parameter int NSLV = 4,
  parameter int AW   = 32,
  parameter logic [NSLV*AW-1:0] BASE = '0,
  parameter logic [NSLV*AW-1:0] MASK = '0
) (
  input  logic [AW-1:0]   addr,
  output logic [NSLV-1:0] hit,
  output logic            miss
);

  // Scan high to low so the lowest matching index is written last.
  always_comb begin
    hit = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
        hit    = '0;
        hit[i] = 1'b1;
      end
    end
  end

  assign miss = ~|hit;

endmodule

// File: rtl/apb_ahb_bridge_n.sv
// apb_ahb_bridge_n: one APB access -> one single-beat AHB-Lite transfer to N slaves.
// Ports: clk, reset (sync, active-high), bus (apb_ahb_bridge_n_if.slave).
module apb_ahb_bridge_n #(
  parameter int NSLV = 4,
  parameter int AW   = 32,
  parameter logic [NSLV*AW-1:0] BASE = '0,
  parameter logic [NSLV*AW-1:0] MASK = '0,
  parameter int TMO  = 255
) (
  input logic clk,
  input logic reset,
  apb_ahb_bridge_n_if.slave bus
);
  import apb_ahb_pkg::*;

  logic [1:0]      state;
  logic [7:0]      cnt;
  logic [31:0]     prdata_q;
  logic            pready_q;
  logic            pslverr_q;
  logic [AW-1:0]   haddr_q;
  logic            hwrite_q;
  logic [2:0]      hsize_q;
  logic [1:0]      htrans_q;
  logic [31:0]     hwdata_q;
  logic [NSLV-1:0] hsel_q;

  logic [NSLV-1:0] hit;
  logic            miss;
  strb_t           sc;
  logic            rdy;
  logic            err;
  logic [31:0]     rdat;

  apb_ahb_decode #(
    .NSLV(NSLV), .AW(AW), .BASE(BASE), .MASK(MASK)
  ) u_dec (
    .addr(bus.paddr),
    .hit (hit),
    .miss(miss)
  );

  assign sc = strb_chk(bus.pwrite, bus.pstrb);

  // Response mux for the selected slave (HSEL is one-hot).
  always_comb begin
    rdy  = 1'b0;
    err  = 1'b0;
    rdat = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (hsel_q[i]) begin
        rdy  = bus.HREADY[i];
        err  = bus.HRESP[2*i +: 2] == HRESP_ERROR;
        rdat = bus.HRDATA[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hsize_q   <= HSIZE_WORD;
      htrans_q  <= HTRANS_IDLE;
      hwdata_q  <= '0;
      hsel_q    <= '0;
    end else begin
      pready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.psel && bus.penable) begin
            if (miss || !sc.ok) begin
              state     <= S_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= '0;
            end else begin
              state    <= S_ADDR;
              hsel_q   <= hit;
              haddr_q  <= {bus.paddr[AW-1:2], sc.lo};
              hwrite_q <= bus.pwrite;
              hsize_q  <= sc.size;
              hwdata_q <= bus.pwdata;
              htrans_q <= HTRANS_NONSEQ;
            end
          end
        end
        S_ADDR: begin
          state    <= S_DATA;
          htrans_q <= HTRANS_IDLE;
          cnt      <= '0;
        end
        S_DATA: begin
          // HREADY is tested first so it wins over a same-cycle timeout.
          if (rdy) begin
            state     <= S_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= err;
            prdata_q  <= hwrite_q ? 32'h0 : rdat;
            hsel_q    <= '0;
          end else if (cnt == 8'(TMO - 1)) begin
            state     <= S_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
            hsel_q    <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.HADDR   = haddr_q;
  assign bus.HWRITE  = hwrite_q;
  assign bus.HSIZE   = hsize_q;
  assign bus.HBURST  = 3'b000;
  assign bus.HTRANS  = htrans_q;
  assign bus.HWDATA  = hwdata_q;
  assign bus.HSEL    = hsel_q;

endmodule

// File: tb/tb_apb_ahb_bridge_n.sv
// tb_apb_ahb_bridge_n: randomized APB master / AHB slave stimulus with a
// transaction-level model; one negedge process compares every cycle.
module tb_apb_ahb_bridge_n;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  apb_ahb_bridge_n_if #(.NSLV(4), .AW(32)) bus ();

  apb_ahb_bridge_n #(
    .NSLV(4),
    .AW  (32),
    .BASE({32'h0400_0000, 32'h0500_0000, 32'h0100_0000, 32'h0000_0000}),
    .MASK({32'hFC00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000}),
    .TMO (TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Address map as the model sees it: region i hits when (a & mask) == base.
  logic [31:0] mbase [4] = '{32'h0000_0000, 32'h0100_0000,
                             32'h0500_0000, 32'h0400_0000};
  logic [31:0] mmask [4] = '{32'hFF00_0000, 32'hFF00_0000,
                             32'hFF00_0000, 32'hFC00_0000};

  typedef struct {
    bit          on;
    bit          rst;
    bit          rdy;
    bit          err;
    bit          chk_a;
    bit          chk_wd;
    bit          w;
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  tr;
    logic [3:0]  sel;
    logic [2:0]  sz;
  } exp_t;

  exp_t e;

  function automatic exp_t idle_e();
    exp_t x;
    x.on = 1; x.rst = 0; x.rdy = 0; x.err = 0;
    x.chk_a = 0; x.chk_wd = 0; x.w = 0;
    x.rd = '0; x.a = '0; x.wd = '0;
    x.tr = 2'b00; x.sel = 4'b0000; x.sz = 3'b010;
    return x;
  endfunction

  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & mmask[i]) == mbase[i]) return i;
    return -1;
  endfunction

  function automatic void model_strb(input bit wr, input logic [3:0] s,
      output bit bad, output logic [2:0] sz, output logic [1:0] lo);
    bad = 0; sz = 3'd2; lo = 2'd0;
    if (!wr || s == 4'hF) return;
    if (s == 4'h3 || s == 4'hC) begin
      sz = 3'd1;
      lo = (s == 4'hC) ? 2'd2 : 2'd0;
      return;
    end
    for (int i = 0; i < 4; i++)
      if (s == 4'(1 << i)) begin
        sz = 3'd0;
        lo = 2'(i);
        return;
      end
    bad = 1;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (e.on) begin
      chk("pready", 32'(bus.pready), 32'(e.rdy));
      chk("htrans", 32'(bus.HTRANS), 32'(e.tr));
      chk("hsel", 32'(bus.HSEL), 32'(e.sel));
      chk("hburst", 32'(bus.HBURST), 32'h0);
      if (e.rdy) begin
        chk("pslverr", 32'(bus.pslverr), 32'(e.err));
        chk("prdata", bus.prdata, e.rd);
      end
      if (e.chk_a) begin
        chk("haddr", bus.HADDR, e.a);
        chk("hwrite", 32'(bus.HWRITE), 32'(e.w));
        chk("hsize", 32'(bus.HSIZE), 32'(e.sz));
      end
      if (e.chk_wd) chk("hwdata", bus.HWDATA, e.wd);
      if (e.rst) begin
        chk("rst_prdata", bus.prdata, 32'h0);
        chk("rst_pslverr", 32'(bus.pslverr), 32'h0);
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
        chk("rst_hsize", 32'(bus.HSIZE), 32'h2);
        chk("rst_hwdata", bus.HWDATA, 32'h0);
      end
    end
  end

  task automatic drive(input int s, input bit rdy, input bit re,
      input logic [31:0] rd);
    bus.HREADY = 4'($urandom);
    bus.HRESP  = 8'($urandom);
    bus.HRDATA = {$urandom, $urandom, $urandom, $urandom};
    if (s >= 0) begin
      bus.HREADY[s] = rdy;
      if (rdy) begin
        bus.HRESP[2*s +: 2]   = re ? 2'b01 : 2'b00;
        bus.HRDATA[32*s +: 32] = rd;
      end
    end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a,
      input logic [31:0] wd, input logic [3:0] st, input int wt,
      input bit re, input logic [31:0] rd, input int rst_at,
      output int lat, output logic [31:0] o_rd, output bit o_err,
      output logic [3:0] o_sel, output logic [31:0] o_addr,
      output logic [2:0] o_sz);
    int s, d, len;
    bit bad, derr, tmo;
    logic [3:0] oh;
    logic [2:0] sz;
    logic [1:0] lo;
    s = model_sel(a);
    model_strb(wr, st, bad, sz, lo);
    derr = bad || (s < 0);
    oh = 4'b0;
    if (!derr) oh[s] = 1'b1;
    tmo = (wt + 1 > TMO);
    d = tmo ? TMO : wt + 1;
    len = derr ? 1 : 2 + d;
    lat = 0; o_rd = '0; o_err = 0; o_sel = '0; o_addr = '0; o_sz = '0;
    bus.psel = 1; bus.penable = 0; bus.pwrite = wr;
    bus.paddr = a; bus.pwdata = wd; bus.pstrb = st;
    drive(-1, 0, 0, 0);
    e = idle_e();
    @(posedge clk); #1;
    bus.penable = 1;
    drive(-1, 0, 0, 0);
    @(posedge clk); #1;
    for (int t = 1; t <= len; t++) begin
      e.rdy = (t == len);
      e.err = derr || tmo || re;
      e.rd = (derr || tmo || wr) ? 32'h0 : rd;
      e.tr = (t == 1 && !derr) ? 2'b10 : 2'b00;
      e.sel = (t < len) ? oh : 4'b0;
      e.chk_a = (t < len);
      e.a = {a[31:2], lo};
      e.w = wr;
      e.sz = sz;
      e.chk_wd = (t < len) && wr;
      e.wd = wd;
      if (t == 1) begin
        o_sel = bus.HSEL; o_addr = bus.HADDR; o_sz = bus.HSIZE;
      end
      if (bus.pready && lat == 0) begin
        lat = t; o_rd = bus.prdata; o_err = bus.pslverr;
      end
      if (t == rst_at) begin
        reset = 1; bus.psel = 0; bus.penable = 0; bus.HREADY = '0;
        @(posedge clk); #1;
        e = idle_e(); e.rst = 1;
        if (bus.pready) lat = -1;
        @(posedge clk); #1;
        reset = 0;
        if (bus.pready) lat = -1;
        @(posedge clk); #1;
        if (bus.pready) lat = -1;
        return;
      end
      drive(derr ? -1 : s, (t - 1) == wt + 1, re, rd);
      if (t == len) begin
        bus.psel = 0; bus.penable = 0;
      end
      @(posedge clk); #1;
    end
    e = idle_e();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish by 200000");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] rd, ad;
    bit er;
    logic [3:0] sl;
    logic [2:0] sz;
    logic [7:0] tops [8] = '{8'h00, 8'h01, 8'h03, 8'h04,
                             8'h05, 8'h06, 8'h07, 8'h80};
    e = idle_e(); e.on = 0;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
    bus.HRDATA = '0; bus.HREADY = '0; bus.HRESP = '0;
    repeat (3) @(posedge clk);
    #1;
    e = idle_e(); e.rst = 1;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    xfer(0, 32'h0100_0010, 0, 4'hF, 0, 0, 32'hCAFE_F00D, 0,
         lat, rd, er, sl, ad, sz);
    chk("d1_lat", 32'(lat), 32'd3);
    chk("d1_prdata", rd, 32'hCAFE_F00D);
    chk("d1_err", 32'(er), 32'd0);
    chk("d1_hsel", 32'(sl), 32'b0010);

    xfer(1, 32'h0000_0004, 32'h1122_3344, 4'hC, 0, 0, 0, 0,
         lat, rd, er, sl, ad, sz);
    chk("d2_lat", 32'(lat), 32'd3);
    chk("d2_haddr", ad, 32'h0000_0006);
    chk("d2_hsize", 32'(sz), 32'd1);
    chk("d2_prdata", rd, 32'h0);

    xfer(0, 32'h0300_0000, 0, 4'hF, 0, 0, 32'h5555_AAAA, 0,
         lat, rd, er, sl, ad, sz);
    chk("d3_lat", 32'(lat), 32'd1);
    chk("d3_err", 32'(er), 32'd1);
    chk("d3_prdata", rd, 32'h0);
    chk("d3_hsel", 32'(sl), 32'b0000);

    xfer(0, 32'h0100_0020, 0, 4'hF, 10, 0, 32'h1234_5678, 0,
         lat, rd, er, sl, ad, sz);
    chk("d4_tmo_lat", 32'(lat), 32'd6);
    chk("d4_tmo_err", 32'(er), 32'd1);

    xfer(0, 32'h0100_0020, 0, 4'hF, 3, 0, 32'h1234_5678, 0,
         lat, rd, er, sl, ad, sz);
    chk("d5_edge_lat", 32'(lat), 32'd6);
    chk("d5_edge_err", 32'(er), 32'd0);
    chk("d5_edge_prdata", rd, 32'h1234_5678);

    xfer(0, 32'h0500_0000, 0, 4'hF, 0, 1, 32'h0BAD_0BAD, 0,
         lat, rd, er, sl, ad, sz);
    chk("d6_hresp_err", 32'(er), 32'd1);
    chk("d6_prio_hsel", 32'(sl), 32'b0100);

    xfer(1, 32'h0400_0008, 32'hDEAD_BEEF, 4'b0101, 0, 0, 0, 0,
         lat, rd, er, sl, ad, sz);
    chk("d7_strb_lat", 32'(lat), 32'd1);
    chk("d7_strb_err", 32'(er), 32'd1);
    chk("d7_strb_hsel", 32'(sl), 32'b0000);

    xfer(0, 32'h0100_0000, 0, 4'hF, 10, 0, 32'h7777_7777, 2,
         lat, rd, er, sl, ad, sz);
    chk("d8_rst_no_pready", 32'(lat), 32'd0);

    xfer(1, 32'h0700_0000, 32'hA5A5_5A5A, 4'b0010, 1, 0, 0, 0,
         lat, rd, er, sl, ad, sz);
    chk("d9_lat", 32'(lat), 32'd4);
    chk("d9_haddr", ad, 32'h0700_0001);
    chk("d9_hsize", 32'(sz), 32'd0);
    chk("d9_hsel", 32'(sl), 32'b1000);
    chk("d9_err", 32'(er), 32'd0);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = {tops[$urandom_range(7)], 24'($urandom) & 24'hFF_FFFC};
      xfer(1'($urandom), a, $urandom, 4'($urandom),
           int'($urandom_range(6)), ($urandom_range(3) == 0), $urandom, 0,
           lat, rd, er, sl, ad, sz);
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
